mem_wb_stage: RTL and testbench

- Memory-to-writeback pipeline stage and producer of the bypass interface consumed by the ID/EX register: mem_wb_rd, imem_wb_data, fmem_wb_data.
- Registers MEM-stage results and performs load-data extraction (byte/half/word, sign/zero extension).
- Selects the integer and FP writeback sources.
- Stalls the pipeline while a load response from data memory is outstanding, with a timeout.

---
 rtl/mem_wb_stage.sv | 235 +++++++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load-data extraction, writeback source select and load-wait stall.
// Optional misaligned-load squash enabled by defining WB_MISALIGN_CHK_EN.
// Ports that do not write a register file carry 0 data and rd 0 to keep bypass compares inert.
module mem_wb_stage #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLEN         = 32,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_mem_valid,
  input  logic [XLEN-1:0] alu_res_I,
  input  logic [FLEN-1:0] falu_res_I,
  input  logic [31:0]     pc_plus4_I,
  input  logic [31:0]     imm_I,
  input  logic [4:0]      rd_I,
  input  logic [1:0]      iSrc_to_Reg_I,
  input  logic            fSrc_to_Reg_I,
  input  logic            RegI_Wr_En_I,
  input  logic            RegF_Wr_En_I,
  input  logic            MEM_Rd_En_I,
  input  logic            LB_I,
  input  logic            LH_I,
  input  logic [2:0]      Funct3_I,
  input  logic [1:0]      addr_lo_I,
  input  logic            dmem_rsp_valid,
  input  logic [31:0]     dmem_rdata,
  output logic [4:0]      mem_wb_rd,
  output logic [XLEN-1:0] imem_wb_data,
  output logic [FLEN-1:0] fmem_wb_data,
  output logic            RegI_Wr_En_O,
  output logic            RegF_Wr_En_O,
  output logic            load_stall_O,
  output logic            bus_err_O,
  output logic            misalign_O
);

  localparam int unsigned CntW = $clog2(LOAD_TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(LOAD_TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StWaitLoad} state_e;

  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [FLEN-1:0] falu_res;
    logic [31:0]     pc_plus4;
    logic [31:0]     imm;
    logic [4:0]      rd;
    logic [1:0]      isrc;
    logic            fsrc;
    logic            regi_we;
    logic            regf_we;
    logic            lb;
    logic            lh;
    logic            ld_unsigned;
    logic [1:0]      addr_lo;
  } mem_op_t;

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] idata;
    logic [FLEN-1:0] fdata;
    logic            iwe;
    logic            fwe;
  } wb_out_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mem_op_t         hold_q, hold_d, in_op, op;
  wb_out_t         out_q, out_d, commit_out;
  logic            bus_err_q, bus_err_d;
  logic            bubble, commit, commit_ok;

  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data, int_val;

  logic unused_funct3;
  assign unused_funct3 = ^Funct3_I[1:0];

  always_comb begin
    in_op             = '0;
    in_op.alu_res     = alu_res_I;
    in_op.falu_res    = falu_res_I;
    in_op.pc_plus4    = pc_plus4_I;
    in_op.imm         = imm_I;
    in_op.rd          = rd_I;
    in_op.isrc        = iSrc_to_Reg_I;
    in_op.fsrc        = fSrc_to_Reg_I;
    in_op.regi_we     = RegI_Wr_En_I;
    in_op.regf_we     = RegF_Wr_En_I;
    in_op.lb          = LB_I;
    in_op.lh          = LH_I;
    in_op.ld_unsigned = Funct3_I[2];
    in_op.addr_lo     = addr_lo_I;
  end

  // While waiting, the committing instruction is the captured load, not the live inputs.
  assign op = (state_q == StWaitLoad) ? hold_q : in_op;

  always_comb begin
    unique case (op.addr_lo)
      2'd0: ld_byte = dmem_rdata[7:0];
      2'd1: ld_byte = dmem_rdata[15:8];
      2'd2: ld_byte = dmem_rdata[23:16];
      2'd3: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = op.addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    if (op.lb) begin
      ld_data = op.ld_unsigned ? XLEN'(ld_byte) : {{(XLEN-8){ld_byte[7]}}, ld_byte};
    end else if (op.lh) begin
      ld_data = op.ld_unsigned ? XLEN'(ld_half) : {{(XLEN-16){ld_half[15]}}, ld_half};
    end else begin
      ld_data = XLEN'(dmem_rdata);
    end

    unique case (op.isrc)
      2'b00: int_val = op.alu_res;
      2'b01: int_val = ld_data;
      2'b10: int_val = XLEN'(op.pc_plus4);
      2'b11: int_val = XLEN'(op.imm);
    endcase

    commit_out       = '0;
    commit_out.iwe   = op.regi_we & (op.rd != 5'd0);
    commit_out.fwe   = op.regf_we;
    commit_out.idata = commit_out.iwe ? int_val : '0;
    commit_out.fdata = commit_out.fwe ? (op.fsrc ? FLEN'(dmem_rdata) : op.falu_res) : '0;
    commit_out.rd    = (commit_out.iwe | commit_out.fwe) ? op.rd : 5'd0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    bubble    = 1'b0;
    commit    = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      StRun: begin
        if (!stall) begin
          if (flush || !ex_mem_valid) begin
            bubble = 1'b1;
          end else if (MEM_Rd_En_I && !dmem_rsp_valid) begin
            hold_d  = in_op;
            bubble  = 1'b1;
            state_d = StWaitLoad;
          end else begin
            commit = 1'b1;
          end
        end
      end
      StWaitLoad: begin
        // A response on the timeout cycle still commits.
        if (dmem_rsp_valid) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = StRun;
        end else if (cnt_q == CntMax) begin
          bubble    = 1'b1;
          bus_err_d = 1'b1;
          cnt_d     = '0;
          state_d   = StRun;
        end else begin
          bubble = 1'b1;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      default: state_d = StRun;
    endcase
  end

`ifdef WB_MISALIGN_CHK_EN
  logic op_is_load, ld_misaligned, misalign_q;

  assign op_is_load    = (state_q == StWaitLoad) | MEM_Rd_En_I;
  assign ld_misaligned = op_is_load &
                         ((op.lh & op.addr_lo[0]) | (!op.lb & !op.lh & (op.addr_lo != 2'b00)));
  assign commit_ok     = commit & !ld_misaligned;

  always_ff @(posedge CLK) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= commit & ld_misaligned;
    end
  end

  assign misalign_O = misalign_q;
`else
  assign commit_ok  = commit;
  assign misalign_O = 1'b0;
`endif

  // Outputs hold only when neither a commit nor a bubble is taken (RUN with stall).
  always_comb begin
    out_d = out_q;
    if (commit_ok) begin
      out_d = commit_out;
    end else if (bubble || commit) begin
      out_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      hold_q    <= '0;
      out_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      out_q     <= out_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign load_stall_O = (state_q == StWaitLoad) |
                        ((state_q == StRun) & !stall & !flush & ex_mem_valid & MEM_Rd_En_I &
                         !dmem_rsp_valid);

  assign mem_wb_rd    = out_q.rd;
  assign imem_wb_data = out_q.idata;
  assign fmem_wb_data = out_q.fdata;
  assign RegI_Wr_En_O = out_q.iwe;
  assign RegF_Wr_En_O = out_q.fwe;
  assign bus_err_O    = bus_err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed cases then randomized traffic against a
// transaction-level model of the stage.
module tb_mem_wb_stage;

  localparam int T = 16;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] falu;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [1:0]  isrc;
    logic        fsrc;
    logic        iwe;
    logic        fwe;
    logic        rd_en;
    logic        lb;
    logic        lh;
    logic [2:0]  f3;
    logic [1:0]  addr;
  } txn_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] idata;
    logic [31:0] fdata;
    logic        iwe;
    logic        fwe;
    logic        berr;
    logic        mis;
  } out_t;

  logic        CLK, rst, stall, flush, valid, rsp;
  logic [31:0] rdata;
  txn_t        cur;

  logic [4:0]  mem_wb_rd;
  logic [31:0] imem_wb_data, fmem_wb_data;
  logic        RegI_Wr_En_O, RegF_Wr_En_O, load_stall_O, bus_err_O, misalign_O;

  mem_wb_stage #(
    .XLEN(32),
    .FLEN(32),
    .LOAD_TIMEOUT(T)
  ) dut (
    .CLK           (CLK),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .ex_mem_valid  (valid),
    .alu_res_I     (cur.alu),
    .falu_res_I    (cur.falu),
    .pc_plus4_I    (cur.pc4),
    .imm_I         (cur.imm),
    .rd_I          (cur.rd),
    .iSrc_to_Reg_I (cur.isrc),
    .fSrc_to_Reg_I (cur.fsrc),
    .RegI_Wr_En_I  (cur.iwe),
    .RegF_Wr_En_I  (cur.fwe),
    .MEM_Rd_En_I   (cur.rd_en),
    .LB_I          (cur.lb),
    .LH_I          (cur.lh),
    .Funct3_I      (cur.f3),
    .addr_lo_I     (cur.addr),
    .dmem_rsp_valid(rsp),
    .dmem_rdata    (rdata),
    .mem_wb_rd     (mem_wb_rd),
    .imem_wb_data  (imem_wb_data),
    .fmem_wb_data  (fmem_wb_data),
    .RegI_Wr_En_O  (RegI_Wr_En_O),
    .RegF_Wr_En_O  (RegF_Wr_En_O),
    .load_stall_O  (load_stall_O),
    .bus_err_O     (bus_err_O),
    .misalign_O    (misalign_O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_pass   = 0;
  bit   stall_q[$];
  out_t exp_q[$];

  // Reference model state: at most one load waiting for its response.
  bit   pend = 0;
  txn_t pend_t;
  int   waited = 0;
  int   lat = 0;
  out_t last_out = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic out_t wb(txn_t t, logic [31:0] word);
    out_t        o = '0;
    int unsigned w = word;
    int unsigned v, ld;
    if (t.lb) begin
      v  = (w >> (8 * t.addr)) & 32'hFF;
      ld = (!t.f3[2] && v >= 128) ? v + 32'hFFFF_FF00 : v;
    end else if (t.lh) begin
      v  = (w >> (16 * t.addr[1])) & 32'hFFFF;
      ld = (!t.f3[2] && v >= 32768) ? v + 32'hFFFF_0000 : v;
    end else begin
      ld = w;
    end
    case (t.isrc)
      2'd0: v = t.alu;
      2'd1: v = ld;
      2'd2: v = t.pc4;
      default: v = t.imm;
    endcase
    o.iwe   = t.iwe && (t.rd != 0);
    o.idata = o.iwe ? v : 0;
    o.fwe   = t.fwe;
    o.fdata = t.fwe ? (t.fsrc ? w : t.falu) : 0;
    o.rd    = (o.iwe || o.fwe) ? t.rd : 0;
    return o;
  endfunction

  task automatic model(output out_t nxt, output bit st);
    st = pend || (!stall && !flush && valid && cur.rd_en && !rsp);
    nxt = last_out;
    nxt.berr = 0;
    nxt.mis = 0;
    if (rst) begin
      nxt = '0;
      pend = 0;
      waited = 0;
    end else if (pend) begin
      if (rsp) begin
        nxt = wb(pend_t, rdata);
        pend = 0;
      end else if (waited + 1 == T) begin
        nxt = '0;
        nxt.berr = 1;
        pend = 0;
      end else begin
        waited++;
        nxt = '0;
      end
    end else if (stall) begin
      // hold
    end else if (flush || !valid) begin
      nxt = '0;
    end else if (cur.rd_en && !rsp) begin
      pend = 1;
      pend_t = cur;
      waited = 0;
      nxt = '0;
    end else begin
      nxt = wb(cur, rdata);
    end
    last_out = nxt;
  endtask

  task automatic step();
    out_t nxt;
    bit   st;
    model(nxt, st);
    stall_q.push_back(st);
    @(posedge CLK);
    exp_q.push_back(nxt);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0; valid = 0; rsp = 0; rdata = '0; cur = '0;
  endtask

  bit   mon_s;
  out_t mon_e;
  always @(negedge CLK) begin
    if (stall_q.size() > 0) begin
      mon_s = stall_q.pop_front();
      chk("load_stall", 32'(load_stall_O), 32'(mon_s));
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("mem_wb_rd", 32'(mem_wb_rd), 32'(mon_e.rd));
      chk("imem_wb_data", imem_wb_data, mon_e.idata);
      chk("fmem_wb_data", fmem_wb_data, mon_e.fdata);
      chk("RegI_Wr_En", 32'(RegI_Wr_En_O), 32'(mon_e.iwe));
      chk("RegF_Wr_En", 32'(RegF_Wr_En_O), 32'(mon_e.fwe));
      chk("bus_err", 32'(bus_err_O), 32'(mon_e.berr));
      chk("misalign", 32'(misalign_O), 32'(mon_e.mis));
    end
  end

  bit was_pend;
  initial begin
    idle();
    rst = 1;
    @(posedge CLK); #1;
    step(); step();
    idle();

    // ALU op to x5
    valid = 1; cur.rd = 5; cur.iwe = 1; cur.alu = 32'h1234; step();
    idle(); step();

    // LB at byte 2, signed then unsigned
    valid = 1; cur.rd = 7; cur.iwe = 1; cur.isrc = 2'b01; cur.rd_en = 1; cur.lb = 1;
    cur.addr = 2; rsp = 1; rdata = 32'h0080_0000; step();
    cur.f3 = 3'b100; step();
    idle(); step();

    // Word load whose response arrives on the third stall cycle
    valid = 1; cur.rd = 9; cur.iwe = 1; cur.isrc = 2'b01; cur.rd_en = 1; step();
    idle(); step();
    rsp = 1; rdata = 32'hCAFE_F00D; step();
    idle(); step();

    // Load that never answers
    valid = 1; cur.rd = 10; cur.iwe = 1; cur.isrc = 2'b01; cur.rd_en = 1; step();
    idle(); stall = 1; flush = 1;
    for (int i = 0; i < T; i++) step();
    idle(); step();

    // Integer write to x0, then FLW to f0
    valid = 1; cur.iwe = 1; cur.alu = 32'hFFFF; step();
    cur = '0; cur.fwe = 1; cur.fsrc = 1; cur.rd_en = 1; rsp = 1; rdata = 32'h3F80_0001; step();

    // Flush a valid op, then hold through a two-cycle stall
    idle(); valid = 1; cur.rd = 3; cur.iwe = 1; cur.alu = 32'h55; step();
    flush = 1; cur.alu = 32'h66; step();
    flush = 0; stall = 1; cur.alu = 32'h77; step(); step();
    idle(); step();

    // Reset while a load is outstanding
    valid = 1; cur.rd = 4; cur.iwe = 1; cur.isrc = 2'b01; cur.rd_en = 1; step();
    idle(); step();
    rst = 1; step();
    idle(); rsp = 1; step();
    idle(); step();

    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 149) == 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      valid = ($urandom_range(0, 4) != 0);
      cur.alu  = $urandom;
      cur.falu = $urandom;
      cur.pc4  = $urandom;
      cur.imm  = $urandom;
      cur.rd   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      cur.isrc = 2'($urandom);
      cur.fsrc = 1'($urandom);
      cur.iwe  = 1'($urandom);
      cur.fwe  = ($urandom_range(0, 3) == 0);
      cur.rd_en = ($urandom_range(0, 2) == 0);
      cur.lb   = 1'b0;
      cur.lh   = 1'b0;
      case ($urandom_range(0, 2))
        0: cur.lb = 1'b1;
        1: cur.lh = 1'b1;
        default: ;
      endcase
      cur.f3   = 3'($urandom);
      cur.addr = 2'($urandom);
      rdata    = $urandom;
      rsp      = pend ? (waited == lat) : 1'($urandom);
      was_pend = pend;
      step();
      if (pend && !was_pend) lat = $urandom_range(0, T + 2);
    end

    idle(); step();
    @(negedge CLK); #1;
    if (exp_q.size() != 0 || stall_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d outputs and %0d stall values never observed, required 0",
               exp_q.size(), stall_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
